// File: rtl/cpu_defs.sv
// rtl/cpu_defs.sv - shared CPU constants: ALU operation codes, datapath width, divider states
package cpu_defs;

   localparam int               DATA_W    = 32;
   localparam logic [31:0]      ZERO_WORD = 32'h0000_0000;

   localparam logic [7:0] ALUOP_NOP  = 8'h00;
   localparam logic [7:0] ALUOP_OR   = 8'h01;
   localparam logic [7:0] ALUOP_AND  = 8'h02;
   localparam logic [7:0] ALUOP_XOR  = 8'h03;
   localparam logic [7:0] ALUOP_NOR  = 8'h04;
   localparam logic [7:0] ALUOP_SLL  = 8'h05;
   localparam logic [7:0] ALUOP_SRL  = 8'h06;
   localparam logic [7:0] ALUOP_SRA  = 8'h07;
   localparam logic [7:0] ALUOP_ADDU = 8'h08;
   localparam logic [7:0] ALUOP_SUBU = 8'h09;
   localparam logic [7:0] ALUOP_SLT  = 8'h0A;
   localparam logic [7:0] ALUOP_SLTU = 8'h0B;
   localparam logic [7:0] ALUOP_MFHI = 8'h0C;
   localparam logic [7:0] ALUOP_MFLO = 8'h0D;
   localparam logic [7:0] ALUOP_DIV  = 8'h0E;
   localparam logic [7:0] ALUOP_DIVU = 8'h0F;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'd0,
      DIV_BUSY = 2'd1,
      DIV_DONE = 2'd2
   } div_state_e;

endpackage

// File: rtl/div_iter.sv
// rtl/div_iter.sv - iterative radix-2 restoring divider with sign fix and annul
//
// Purpose: divides dividend by divisor over W BUSY cycles, one quotient bit per cycle.
//          Signed ops divide magnitudes and fix signs on the way out.
// Ports:
//   clk, rst           clock, asynchronous active-low reset
//   start              begin a divide (sampled only in IDLE)
//   signed_op          1 = DIV semantics, 0 = DIVU
//   dividend, divisor  operands, sampled on the start edge only
//   annul              abort: next state IDLE from any state
//   busy               FSM is in BUSY
//   done               FSM is in DONE; quotient/remainder are final
//   quotient           sign-corrected quotient
//   remainder          sign-corrected remainder
module div_iter
   import cpu_defs::*;
#(
   parameter int W = DATA_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         signed_op,
   input  logic [W-1:0] dividend,
   input  logic [W-1:0] divisor,
   input  logic         annul,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] quotient,
   output logic [W-1:0] remainder
);

   localparam int CW = $clog2(W + 1);

   div_state_e      r_state;
   logic [CW-1:0]   r_count;
   logic [W-1:0]    r_quo;     // dividend bits shift out the top, quotient bits shift in the bottom
   logic [W-1:0]    r_rem;
   logic [W-1:0]    r_dsr;
   logic            r_neg_q;
   logic            r_neg_r;

   logic [W-1:0]    w_abs_dvd;
   logic [W-1:0]    w_abs_dsr;
   logic [W:0]      w_shift;
   logic [W:0]      w_diff;
   logic            w_ge;

   assign w_abs_dvd = (signed_op && dividend[W-1]) ? (~dividend + 1'b1) : dividend;
   assign w_abs_dsr = (signed_op && divisor[W-1])  ? (~divisor + 1'b1)  : divisor;

   // Partial remainder is always < divisor, so one extra bit holds the shifted value.
   assign w_shift = {r_rem, r_quo[W-1]};
   assign w_diff  = w_shift - {1'b0, r_dsr};
   assign w_ge    = ~w_diff[W];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= DIV_IDLE;
         r_count <= '0;
         r_quo   <= '0;
         r_rem   <= '0;
         r_dsr   <= '0;
         r_neg_q <= 1'b0;
         r_neg_r <= 1'b0;
      end else if (annul) begin
         r_state <= DIV_IDLE;
      end else begin
         case (r_state)
            DIV_IDLE: begin
               if (start) begin
                  r_count <= '0;
                  if (divisor == '0) begin
                     // Divide by zero: preload the fixed result and skip BUSY.
                     r_quo   <= '1;
                     r_rem   <= dividend;
                     r_dsr   <= '0;
                     r_neg_q <= 1'b0;
                     r_neg_r <= 1'b0;
                     r_state <= DIV_DONE;
                  end else begin
                     r_quo   <= w_abs_dvd;
                     r_rem   <= '0;
                     r_dsr   <= w_abs_dsr;
                     r_neg_q <= signed_op && (dividend[W-1] ^ divisor[W-1]);
                     r_neg_r <= signed_op && dividend[W-1];
                     r_state <= DIV_BUSY;
                  end
               end
            end
            DIV_BUSY: begin
               r_count <= r_count + CW'(1);
               r_rem   <= w_ge ? w_diff[W-1:0] : w_shift[W-1:0];
               r_quo   <= {r_quo[W-2:0], w_ge};
               if (r_count == CW'(W - 1)) begin
                  r_state <= DIV_DONE;
               end
            end
            DIV_DONE: begin
               r_state <= DIV_IDLE;
            end
            default: begin
               r_state <= DIV_IDLE;
            end
         endcase
      end
   end

   assign busy      = (r_state == DIV_BUSY);
   assign done      = (r_state == DIV_DONE);
   assign quotient  = r_neg_q ? (~r_quo + 1'b1) : r_quo;
   assign remainder = r_neg_r ? (~r_rem + 1'b1) : r_rem;

endmodule

// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - execute stage: single-cycle ALU, HI/LO pair, iterative divide with stall
//
// Purpose: computes the write-back tuple for ex_mem; DIV/DIVU stall the pipe while the
//          divider runs and land their result in HI/LO on the edge leaving DONE.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   aluop_i         operation code (cpu_defs ALUOP_*)
//   reg1_i, reg2_i  operands; shift amount is reg2_i[4:0]
//   wd_i, wreg_i    destination index / write enable from id_ex
//   flush_i         pipeline flush, aborts a divide
//   wd_o, wreg_o    destination index / write enable to ex_mem
//   wdata_o         GPR write data
//   stallreq        freeze request for the upstream pipe
module ex_stage
   import cpu_defs::*;
#(
   parameter int DATA_W = cpu_defs::DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        aluop_i,
   input  logic [DATA_W-1:0] reg1_i,
   input  logic [DATA_W-1:0] reg2_i,
   input  logic [4:0]        wd_i,
   input  logic              wreg_i,
   input  logic              flush_i,
   output logic [4:0]        wd_o,
   output logic              wreg_o,
   output logic [DATA_W-1:0] wdata_o,
   output logic              stallreq
);

   logic [DATA_W-1:0] r_hi;
   logic [DATA_W-1:0] r_lo;

   logic              w_is_div;
   logic              w_div_busy;
   logic              w_div_done;
   logic [DATA_W-1:0] w_quotient;
   logic [DATA_W-1:0] w_remainder;
   logic [4:0]        w_shamt;
   logic [DATA_W-1:0] w_wdata;
   logic              w_writes;

   assign w_is_div = (aluop_i == ALUOP_DIV) || (aluop_i == ALUOP_DIVU);
   assign w_shamt  = reg2_i[4:0];

   div_iter #(.W(DATA_W)) u_div (
      .clk       (clk),
      .rst       (rst),
      .start     (w_is_div && !flush_i),
      .signed_op (aluop_i == ALUOP_DIV),
      .dividend  (reg1_i),
      .divisor   (reg2_i),
      .annul     (flush_i),
      .busy      (w_div_busy),
      .done      (w_div_done),
      .quotient  (w_quotient),
      .remainder (w_remainder)
   );

   // The edge leaving DONE is also the edge on which id_ex advances, so the
   // following instruction already reads the new HI/LO.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_hi <= '0;
         r_lo <= '0;
      end else if (w_div_done && !flush_i) begin
         r_hi <= w_remainder;
         r_lo <= w_quotient;
      end
   end

   // Stall covers the load cycle in IDLE and every BUSY cycle; DONE releases the pipe.
   assign stallreq = rst && !flush_i &&
                     ((w_is_div && !w_div_busy && !w_div_done) || w_div_busy);

   always_comb begin
      w_wdata  = '0;
      w_writes = 1'b1;
      case (aluop_i)
         ALUOP_OR:   w_wdata = reg1_i | reg2_i;
         ALUOP_AND:  w_wdata = reg1_i & reg2_i;
         ALUOP_XOR:  w_wdata = reg1_i ^ reg2_i;
         ALUOP_NOR:  w_wdata = ~(reg1_i | reg2_i);
         ALUOP_SLL:  w_wdata = reg1_i << w_shamt;
         ALUOP_SRL:  w_wdata = reg1_i >> w_shamt;
         ALUOP_SRA:  w_wdata = $signed(reg1_i) >>> w_shamt;
         ALUOP_ADDU: w_wdata = reg1_i + reg2_i;
         ALUOP_SUBU: w_wdata = reg1_i - reg2_i;
         ALUOP_SLT:  w_wdata = {{(DATA_W-1){1'b0}}, ($signed(reg1_i) < $signed(reg2_i))};
         ALUOP_SLTU: w_wdata = {{(DATA_W-1){1'b0}}, (reg1_i < reg2_i)};
         ALUOP_MFHI: w_wdata = r_hi;
         ALUOP_MFLO: w_wdata = r_lo;
         default:    w_writes = 1'b0;   // NOP, DIV, DIVU, unknown codes
      endcase
   end

   assign wd_o    = wd_i;
   assign wreg_o  = wreg_i && w_writes;
   assign wdata_o = w_wdata;

endmodule

// File: tb/tb_ex_stage.sv
// tb/tb_ex_stage.sv - directed self-checking bench for ex_stage
module tb_ex_stage;
   import cpu_defs::*;

   logic        clk;
   logic        rst;
   logic [7:0]  aluop_i;
   logic [31:0] reg1_i;
   logic [31:0] reg2_i;
   logic [4:0]  wd_i;
   logic        wreg_i;
   logic        flush_i;
   logic [4:0]  wd_o;
   logic        wreg_o;
   logic [31:0] wdata_o;
   logic        stallreq;

   int n_checks;
   int n_errors;

   ex_stage #(.DATA_W(32)) dut (
      .clk      (clk),
      .rst      (rst),
      .aluop_i  (aluop_i),
      .reg1_i   (reg1_i),
      .reg2_i   (reg2_i),
      .wd_i     (wd_i),
      .wreg_i   (wreg_i),
      .flush_i  (flush_i),
      .wd_o     (wd_o),
      .wreg_o   (wreg_o),
      .wdata_o  (wdata_o),
      .stallreq (stallreq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one single-cycle op and let combinational outputs settle.
   task automatic drive_op(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
      aluop_i = op;
      reg1_i  = a;
      reg2_i  = b;
      #1;
   endtask

   // Issue a divide (called just after a posedge) and count stall cycles until DONE.
   task automatic issue_div(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                            output int stalls);
      drive_op(op, a, b);
      stalls = 0;
      while (stallreq === 1'b1 && stalls < 100) begin
         stalls++;
         @(posedge clk);
         #1;
      end
   endtask

   // Cross the edge that leaves DONE; id_ex moves on to the next op.
   task automatic leave_done(input logic [7:0] next_op);
      @(posedge clk);
      #1;
      drive_op(next_op, 32'h0, 32'h0);
   endtask

   task automatic test_reset;
      rst = 1'b0; aluop_i = ALUOP_NOP; reg1_i = 32'h0; reg2_i = 32'h0;
      wd_i = 5'd0; wreg_i = 1'b1; flush_i = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if (stallreq !== 1'b0) begin n_errors++; $display("FAIL reset_stall got %b want 0", stallreq); end
      n_checks++;
      if (wdata_o !== 32'h0) begin n_errors++; $display("FAIL reset_wdata got %h want 0", wdata_o); end
      n_checks++;
      if (wreg_o !== 1'b0) begin n_errors++; $display("FAIL reset_nop_wreg got %b want 0", wreg_o); end
      drive_op(ALUOP_MFHI, 32'h0, 32'h0);
      n_checks++;
      if (wdata_o !== 32'h0) begin n_errors++; $display("FAIL reset_hi got %h want 0", wdata_o); end
      drive_op(ALUOP_MFLO, 32'h0, 32'h0);
      n_checks++;
      if (wdata_o !== 32'h0) begin n_errors++; $display("FAIL reset_lo got %h want 0", wdata_o); end
      @(posedge clk);
      #1;
      rst = 1'b1;
      aluop_i = ALUOP_NOP;
   endtask

   task automatic test_arith;
      wd_i = 5'd17; wreg_i = 1'b1;
      drive_op(ALUOP_ADDU, 32'h7FFF_FFFF, 32'h1);
      n_checks++;
      if (wdata_o !== 32'h8000_0000) begin n_errors++; $display("FAIL addu got %h want 80000000", wdata_o); end
      n_checks++;
      if (wreg_o !== 1'b1 || wd_o !== 5'd17) begin n_errors++; $display("FAIL addu_wb got wreg=%b wd=%0d want wreg=1 wd=17", wreg_o, wd_o); end
      drive_op(ALUOP_SUBU, 32'h0, 32'h1);
      n_checks++;
      if (wdata_o !== 32'hFFFF_FFFF) begin n_errors++; $display("FAIL subu got %h want ffffffff", wdata_o); end
      drive_op(ALUOP_SLT, 32'hFFFF_FFFF, 32'h1);
      n_checks++;
      if (wdata_o !== 32'h1) begin n_errors++; $display("FAIL slt got %h want 1", wdata_o); end
      drive_op(ALUOP_SLTU, 32'hFFFF_FFFF, 32'h1);
      n_checks++;
      if (wdata_o !== 32'h0) begin n_errors++; $display("FAIL sltu got %h want 0", wdata_o); end
      drive_op(ALUOP_OR, 32'hF0F0_0000, 32'h0000_0F0F);
      n_checks++;
      if (wdata_o !== 32'hF0F0_0F0F) begin n_errors++; $display("FAIL or got %h want f0f00f0f", wdata_o); end
      drive_op(ALUOP_AND, 32'hFF00_FF00, 32'h0FF0_0FF0);
      n_checks++;
      if (wdata_o !== 32'h0F00_0F00) begin n_errors++; $display("FAIL and got %h want 0f000f00", wdata_o); end
      drive_op(ALUOP_XOR, 32'hFFFF_0000, 32'h0F0F_0F0F);
      n_checks++;
      if (wdata_o !== 32'hF0F0_0F0F) begin n_errors++; $display("FAIL xor got %h want f0f00f0f", wdata_o); end
      drive_op(ALUOP_NOR, 32'hFFFF_0000, 32'h0000_00FF);
      n_checks++;
      if (wdata_o !== 32'h0000_FF00) begin n_errors++; $display("FAIL nor got %h want 0000ff00", wdata_o); end
      drive_op(8'h7E, 32'h1234_5678, 32'h1);
      n_checks++;
      if (wdata_o !== 32'h0 || wreg_o !== 1'b0) begin n_errors++; $display("FAIL unknown_op got data=%h wreg=%b want 0/0", wdata_o, wreg_o); end
   endtask

   task automatic test_shift;
      drive_op(ALUOP_SRA, 32'h8000_0000, 32'h4);
      n_checks++;
      if (wdata_o !== 32'hF800_0000) begin n_errors++; $display("FAIL sra got %h want f8000000", wdata_o); end
      drive_op(ALUOP_SRL, 32'h8000_0000, 32'h4);
      n_checks++;
      if (wdata_o !== 32'h0800_0000) begin n_errors++; $display("FAIL srl got %h want 08000000", wdata_o); end
      // upper bits of reg2 must be ignored: 0xFFFFFFFF -> shamt 31
      drive_op(ALUOP_SLL, 32'h1, 32'hFFFF_FFFF);
      n_checks++;
      if (wdata_o !== 32'h8000_0000) begin n_errors++; $display("FAIL sll got %h want 80000000", wdata_o); end
   endtask

   task automatic test_divu;
      int s;
      @(posedge clk);
      #1;
      issue_div(ALUOP_DIVU, 32'd100, 32'd7, s);
      n_checks++;
      if (s != 33) begin n_errors++; $display("FAIL divu_stall_cycles got %0d want 33", s); end
      n_checks++;
      if (wreg_o !== 1'b0) begin n_errors++; $display("FAIL divu_wreg got %b want 0", wreg_o); end
      leave_done(ALUOP_MFLO);
      n_checks++;
      if (wdata_o !== 32'd14) begin n_errors++; $display("FAIL divu_lo got %h want 0000000e", wdata_o); end
      drive_op(ALUOP_MFHI, 32'h0, 32'h0);
      n_checks++;
      if (wdata_o !== 32'd2) begin n_errors++; $display("FAIL divu_hi got %h want 00000002", wdata_o); end
   endtask

   task automatic test_div_signed;
      int s;
      @(posedge clk);
      #1;
      issue_div(ALUOP_DIV, 32'hFFFF_FFF9, 32'd2, s);
      n_checks++;
      if (s != 33) begin n_errors++; $display("FAIL div_neg_stall got %0d want 33", s); end
      leave_done(ALUOP_MFLO);
      n_checks++;
      if (wdata_o !== 32'hFFFF_FFFD) begin n_errors++; $display("FAIL div_neg_lo got %h want fffffffd", wdata_o); end
      drive_op(ALUOP_MFHI, 32'h0, 32'h0);
      n_checks++;
      if (wdata_o !== 32'hFFFF_FFFF) begin n_errors++; $display("FAIL div_neg_hi got %h want ffffffff", wdata_o); end
      @(posedge clk);
      #1;
      issue_div(ALUOP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, s);
      leave_done(ALUOP_MFLO);
      n_checks++;
      if (wdata_o !== 32'h8000_0000) begin n_errors++; $display("FAIL div_min_lo got %h want 80000000", wdata_o); end
      drive_op(ALUOP_MFHI, 32'h0, 32'h0);
      n_checks++;
      if (wdata_o !== 32'h0) begin n_errors++; $display("FAIL div_min_hi got %h want 0", wdata_o); end
   endtask

   task automatic test_div_zero;
      int s;
      @(posedge clk);
      #1;
      issue_div(ALUOP_DIV, 32'd5, 32'd0, s);
      n_checks++;
      if (s != 1) begin n_errors++; $display("FAIL divzero_stall got %0d want 1", s); end
      leave_done(ALUOP_MFLO);
      n_checks++;
      if (wdata_o !== 32'hFFFF_FFFF) begin n_errors++; $display("FAIL divzero_lo got %h want ffffffff", wdata_o); end
      drive_op(ALUOP_MFHI, 32'h0, 32'h0);
      n_checks++;
      if (wdata_o !== 32'd5) begin n_errors++; $display("FAIL divzero_hi got %h want 00000005", wdata_o); end
   endtask

   // Entry: HI=5, LO=0xFFFFFFFF from the divide-by-zero case.
   task automatic test_flush;
      int s;
      @(posedge clk);
      #1;
      drive_op(ALUOP_DIVU, 32'd9, 32'd3);
      repeat (11) @(posedge clk);
      #1;
      n_checks++;
      if (stallreq !== 1'b1) begin n_errors++; $display("FAIL flush_pre_stall got %b want 1", stallreq); end
      flush_i = 1'b1;
      #1;
      n_checks++;
      if (stallreq !== 1'b0) begin n_errors++; $display("FAIL flush_stall got %b want 0", stallreq); end
      @(posedge clk);
      #1;
      flush_i = 1'b0;
      drive_op(ALUOP_MFLO, 32'h0, 32'h0);
      n_checks++;
      if (wdata_o !== 32'hFFFF_FFFF) begin n_errors++; $display("FAIL flush_lo_kept got %h want ffffffff", wdata_o); end
      drive_op(ALUOP_MFHI, 32'h0, 32'h0);
      n_checks++;
      if (wdata_o !== 32'd5) begin n_errors++; $display("FAIL flush_hi_kept got %h want 00000005", wdata_o); end
      // A fresh issue after the flush must run a full divide from IDLE.
      @(posedge clk);
      #1;
      issue_div(ALUOP_DIVU, 32'd9, 32'd3, s);
      n_checks++;
      if (s != 33) begin n_errors++; $display("FAIL flush_restart_stall got %0d want 33", s); end
      leave_done(ALUOP_MFLO);
      n_checks++;
      if (wdata_o !== 32'd3) begin n_errors++; $display("FAIL flush_restart_lo got %h want 00000003", wdata_o); end
   endtask

   task automatic test_async_reset;
      int s;
      @(posedge clk);
      #1;
      issue_div(ALUOP_DIV, 32'd5, 32'd0, s);
      leave_done(ALUOP_NOP);
      @(posedge clk);
      #1;
      drive_op(ALUOP_DIVU, 32'd9, 32'd3);
      repeat (11) @(posedge clk);
      #3;
      rst = 1'b0;
      #1;
      n_checks++;
      if (stallreq !== 1'b0) begin n_errors++; $display("FAIL rst_mid_stall got %b want 0", stallreq); end
      drive_op(ALUOP_MFHI, 32'h0, 32'h0);
      n_checks++;
      if (wdata_o !== 32'h0) begin n_errors++; $display("FAIL rst_mid_hi got %h want 0", wdata_o); end
      drive_op(ALUOP_MFLO, 32'h0, 32'h0);
      n_checks++;
      if (wdata_o !== 32'h0) begin n_errors++; $display("FAIL rst_mid_lo got %h want 0", wdata_o); end
      aluop_i = ALUOP_NOP;
      @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      n_checks++;
      if (stallreq !== 1'b0) begin n_errors++; $display("FAIL rst_release_stall got %b want 0", stallreq); end
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      test_reset();
      test_arith();
      test_shift();
      test_divu();
      test_div_signed();
      test_div_zero();
      test_flush();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
